// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
// Shared types and constants for the 8x8 RGB LED matrix scan controller.
//   row_t        : 3-bit matrix row index
//   scan_state_t : scan FSM states (BLANK only when GHOST_BLANK_EN is defined)
//   src_t        : picture source latched once per frame
//   rgb_t        : one row of active-low red/green/blue column data
//   START_PIC    : start-screen picture, shown on the green plane
//   OVER_PIC     : level-over picture, shown on the blue plane
//   BLANK_ROW    : all columns off (active-low)
// Optional feature macro: GHOST_BLANK_EN (adds the BLANK state).
// ---------------------------------------------------------------------------
package matrix_pkg;

  typedef logic [2:0] row_t;

  localparam logic [7:0] BLANK_ROW = 8'hFF;

  // Fixed encodings so the state register matches the legacy layout.
  localparam logic [1:0] ST_SCAN   = 2'd0;
  localparam logic [1:0] ST_BLANK  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  typedef enum logic [1:0] {
    SCAN   = ST_SCAN,
`ifdef GHOST_BLANK_EN
    BLANK  = ST_BLANK,
`endif
    UPDATE = ST_UPDATE
  } scan_state_t;

  typedef enum logic [1:0] {
    SRC_FBUF  = 2'd0,
    SRC_START = 2'd1,
    SRC_OVER  = 2'd2
  } src_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Row 0 is the leftmost element; data is active-low (0 = LED on).
  localparam logic [0:7][7:0] START_PIC = {
    8'hC3, 8'hBD, 8'h5A, 8'h7E, 8'h5A, 8'h66, 8'hBD, 8'hC3
  };

  localparam logic [0:7][7:0] OVER_PIC = {
    8'h7E, 8'hBD, 8'hDB, 8'hE7, 8'hE7, 8'hDB, 8'hBD, 8'h7E
  };

  // Picture source for a new frame: the start screen wins over everything,
  // the over screen needs the game running, otherwise the frame buffer.
  function automatic src_t pick_src(input logic ready, input logic done);
    src_t s;
    if (!ready) begin
      s = SRC_START;
    end else if (done) begin
      s = SRC_OVER;
    end else begin
      s = SRC_FBUF;
    end
    return s;
  endfunction

  function automatic rgb_t blank_rgb();
    return '{r: BLANK_ROW, g: BLANK_ROW, b: BLANK_ROW};
  endfunction

endpackage

// File: rtl/matrix_fbuf.sv
// ---------------------------------------------------------------------------
// matrix_fbuf
// Frame-buffer register file: three colour planes of ROWS x 8 bits, one
// write port and one asynchronous read port. All bits reset to 1 (blank).
// Ports:
//   CLK_div1000          : clock
//   reset                : synchronous, active-high reset
//   wr_en                : write strobe, stores wr_r/wr_g/wr_b at wr_row
//   wr_row, wr_r/g/b     : write address and active-low row data
//   rd_row               : read address
//   rd_r, rd_g, rd_b     : read data for rd_row
// ---------------------------------------------------------------------------
module matrix_fbuf
  import matrix_pkg::*;
#(
  parameter int ROWS = 8
) (
  input  logic       CLK_div1000,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_r,
  input  logic [7:0] wr_g,
  input  logic [7:0] wr_b,
  input  logic [2:0] rd_row,
  output logic [7:0] rd_r,
  output logic [7:0] rd_g,
  output logic [7:0] rd_b
);

  logic [7:0] red_r [ROWS];
  logic [7:0] grn_r [ROWS];
  logic [7:0] blu_r [ROWS];

  // Row storage; reset wins over a coincident write so that write is lost.
  always_ff @(posedge CLK_div1000) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        red_r[i] <= BLANK_ROW;
        grn_r[i] <= BLANK_ROW;
        blu_r[i] <= BLANK_ROW;
      end
    end else if (wr_en) begin
      red_r[wr_row] <= wr_r;
      grn_r[wr_row] <= wr_g;
      blu_r[wr_row] <= wr_b;
    end
  end

  assign rd_r = red_r[rd_row];
  assign rd_g = grn_r[rd_row];
  assign rd_b = blu_r[rd_row];

endmodule

// File: rtl/matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_scan_ctrl
// Row-scan controller for an 8x8 RGB LED matrix with a double-role frame
// buffer: rows are scanned continuously, and game-logic row writes are only
// accepted in an UPDATE window inserted at a frame boundary (no tearing).
// Ports:
//   CLK_div1000      : scan clock
//   reset            : synchronous, active-high reset
//   ready, done      : game state; picks start / over / frame-buffer picture
//   wr_req           : row write request from game logic
//   wr_row, wr_r/g/b : row index and active-low row data
//   wr_ack           : combinational, write accepted this cycle
//   R, G, B          : registered active-low column drive
//   A                : registered row address {row, 1'b1}
//   com              : 7-segment digit enable, alternates 4'b1110/4'b1101
//   frame_start      : one-cycle pulse while row 0 is on the outputs
// Optional feature macro: GHOST_BLANK_EN -- inserts one BLANK cycle after
// every scanned row (16-cycle frame instead of 8).
// ---------------------------------------------------------------------------
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int UPD_MAX = 8
) (
  input  logic       CLK_div1000,
  input  logic       reset,
  input  logic       ready,
  input  logic       done,
  input  logic       wr_req,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_r,
  input  logic [7:0] wr_g,
  input  logic [7:0] wr_b,
  output logic       wr_ack,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic [3:0] A,
  output logic [3:0] com,
  output logic       frame_start
);

  localparam int               CNT_W     = $clog2(UPD_MAX + 1);
  localparam row_t             ROW_LAST  = row_t'(ROWS - 1);
  localparam logic [CNT_W-1:0] UPD_LIMIT = CNT_W'(UPD_MAX);

`ifdef GHOST_BLANK_EN
  localparam scan_state_t AFTER_ROW = BLANK;
`else
  localparam scan_state_t AFTER_ROW = SCAN;
`endif

  scan_state_t      state_r;
  scan_state_t      state_nxt_s;
  row_t             row_r;
  row_t             row_next_s;
  src_t             src_r;
  src_t             src_now_s;
  logic [CNT_W-1:0] upd_cnt_r;

  logic [7:0] r_out_r;
  logic [7:0] g_out_r;
  logic [7:0] b_out_r;
  logic [3:0] a_out_r;
  logic [3:0] com_r;
  logic       fs_r;

  logic       upd_full_s;
  logic       ack_s;
  logic       enter_upd_s;
  logic       leave_upd_s;
  logic       show_row_s;
  logic       new_frame_s;
  rgb_t       pix_s;
  logic [7:0] fb_r_s;
  logic [7:0] fb_g_s;
  logic [7:0] fb_b_s;

  matrix_fbuf #(
    .ROWS (ROWS)
  ) u_fbuf (
    .CLK_div1000 (CLK_div1000),
    .reset       (reset),
    .wr_en       (ack_s),
    .wr_row      (wr_row),
    .wr_r        (wr_r),
    .wr_g        (wr_g),
    .wr_b        (wr_b),
    .rd_row      (row_r),
    .rd_r        (fb_r_s),
    .rd_g        (fb_g_s),
    .rd_b        (fb_b_s)
  );

  // Handshake and sequencing decisions for the current cycle. The row counter
  // parks at 0 for the whole UPDATE window, so leaving UPDATE shows row 0.
  always_comb begin
    upd_full_s  = (upd_cnt_r == UPD_LIMIT);
    ack_s       = !reset && (state_r == UPDATE) && wr_req && !upd_full_s;
    enter_upd_s = (state_r == SCAN) && (row_r == 3'd0) && wr_req;
    leave_upd_s = (state_r == UPDATE) && (!wr_req || upd_full_s);
    show_row_s  = ((state_r == SCAN) && !enter_upd_s) || leave_upd_s;
    new_frame_s = show_row_s && (row_r == 3'd0);
    row_next_s  = (row_r == ROW_LAST) ? 3'd0 : (row_r + 3'd1);
  end

  // Picture source: sampled from ready/done only when a frame begins, so a
  // mid-frame change cannot tear the picture.
  always_comb begin
    if (new_frame_s) begin
      src_now_s = pick_src(ready, done);
    end else begin
      src_now_s = src_r;
    end
  end

  // Column data for the row being driven, from the selected source.
  always_comb begin
    pix_s = blank_rgb();
    case (src_now_s)
      SRC_START: pix_s.g = START_PIC[row_r];
      SRC_OVER:  pix_s.b = OVER_PIC[row_r];
      SRC_FBUF:  pix_s   = '{r: fb_r_s, g: fb_g_s, b: fb_b_s};
      default:   pix_s   = blank_rgb();
    endcase
  end

  // Next-state logic for the scan FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SCAN: begin
        if (enter_upd_s) begin
          state_nxt_s = UPDATE;
        end else begin
          state_nxt_s = AFTER_ROW;
        end
      end
`ifdef GHOST_BLANK_EN
      BLANK: state_nxt_s = SCAN;
`endif
      UPDATE: begin
        if (leave_upd_s) begin
          state_nxt_s = AFTER_ROW;
        end else begin
          state_nxt_s = UPDATE;
        end
      end
      default: state_nxt_s = SCAN;
    endcase
  end

  // FSM state, row counter and latched picture source.
  always_ff @(posedge CLK_div1000) begin
    if (reset) begin
      state_r <= SCAN;
      row_r   <= 3'd0;
      src_r   <= SRC_FBUF;
    end else begin
      state_r <= state_nxt_s;
      if (show_row_s) begin
        row_r <= row_next_s;
        src_r <= src_now_s;
      end
    end
  end

  // Count of writes accepted in the current UPDATE window.
  always_ff @(posedge CLK_div1000) begin
    if (reset) begin
      upd_cnt_r <= '0;
    end else if (enter_upd_s) begin
      upd_cnt_r <= '0;
    end else if (ack_s) begin
      upd_cnt_r <= upd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Registered panel outputs: a shown row drives data and address together;
  // UPDATE and BLANK cycles blank the columns and keep the address.
  always_ff @(posedge CLK_div1000) begin
    if (reset) begin
      r_out_r <= BLANK_ROW;
      g_out_r <= BLANK_ROW;
      b_out_r <= BLANK_ROW;
      a_out_r <= 4'b0001;
      fs_r    <= 1'b0;
    end else if (show_row_s) begin
      r_out_r <= pix_s.r;
      g_out_r <= pix_s.g;
      b_out_r <= pix_s.b;
      a_out_r <= {row_r, 1'b1};
      fs_r    <= new_frame_s;
    end else begin
      r_out_r <= BLANK_ROW;
      g_out_r <= BLANK_ROW;
      b_out_r <= BLANK_ROW;
      fs_r    <= 1'b0;
    end
  end

  // Digit enable alternates every cycle regardless of FSM state.
  always_ff @(posedge CLK_div1000) begin
    if (reset) begin
      com_r <= 4'b1110;
    end else if (com_r == 4'b1110) begin
      com_r <= 4'b1101;
    end else begin
      com_r <= 4'b1110;
    end
  end

  assign wr_ack      = ack_s;
  assign R           = r_out_r;
  assign G           = g_out_r;
  assign B           = b_out_r;
  assign A           = a_out_r;
  assign com         = com_r;
  assign frame_start = fs_r;

endmodule
